// File: rtl/decimal_entry_encoder_pkg.sv
// Shared types, constants and the x10 accumulate helper for the decimal entry encoder.
package decimal_entry_pkg;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ENTRY  = 2'd1,
    RESULT = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [3:0] DIGIT_MAX         = 4'd9;
  localparam int         ACC_W             = 10;
  localparam logic [7:0] DEFAULT_MAX_VALUE = 8'd150;

  // Shift-and-add form of acc*10 + digit; ACC_W bits hold 999 without wrapping.
  function automatic logic [ACC_W-1:0] times_ten_plus(input logic [ACC_W-1:0] acc,
                                                      input logic [3:0]       digit);
    return (acc << 3) + (acc << 1) + {{(ACC_W-4){1'b0}}, digit};
  endfunction

endpackage

// File: rtl/decimal_entry_encoder_if.sv
// Digit-in / value-out handshake bundle of the decimal entry encoder.
interface decimal_entry_encoder_if;

  logic       digit_valid;
  logic [3:0] digit;
  logic       digit_ready;
  logic       enter;
  logic       clear;
  logic [7:0] value;
  logic       value_valid;
  logic       value_ready;
  logic       error;
  logic [1:0] digit_count;

  modport master (
    output digit_valid, digit, enter, clear, value_ready,
    input  digit_ready, value, value_valid, error, digit_count
  );

  modport slave (
    input  digit_valid, digit, enter, clear, value_ready,
    output digit_ready, value, value_valid, error, digit_count
  );

endinterface

// File: rtl/decimal_entry_encoder.sv
// Accumulates MSD-first decimal digits into an 8-bit value limited to 0..MAX_VALUE.
// Define DECIMAL_ENTRY_AUTO_COMMIT_EN to commit implicitly on the MAX_DIGITS-th digit.
module decimal_entry_encoder
  import decimal_entry_pkg::*;
#(
  parameter int MAX_VALUE  = int'(DEFAULT_MAX_VALUE),
  parameter int MAX_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  decimal_entry_encoder_if.slave  bus
);

  localparam logic [ACC_W-1:0] MAX_ACC = ACC_W'(MAX_VALUE);
  localparam logic [1:0]       MAX_CNT = 2'(MAX_DIGITS);

`ifdef DECIMAL_ENTRY_AUTO_COMMIT_EN
  localparam logic AUTO_COMMIT = 1'b1;
`else
  localparam logic AUTO_COMMIT = 1'b0;
`endif

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [1:0]       cnt;
  logic [7:0]       value_q;
  logic             value_valid_q;
  logic             error_q;

  logic             digit_ready;
  logic             offer;
  logic             accept;
  logic             illegal;
  logic [ACC_W-1:0] acc_app;
  logic [1:0]       cnt_app;
  logic             commit;

  // Pure decode of registered state; never looks at digit_valid.
  assign digit_ready = (state == EMPTY) || ((state == ENTRY) && (cnt < MAX_CNT));

  assign offer   = bus.digit_valid && digit_ready;
  assign accept  = offer && (bus.digit <= DIGIT_MAX);
  assign illegal = offer && (bus.digit > DIGIT_MAX);

  // A digit accepted alongside enter is appended before the range check.
  assign acc_app = accept ? times_ten_plus(acc, bus.digit) : acc;
  assign cnt_app = accept ? cnt + 2'd1 : cnt;
  assign commit  = (bus.enter && ((state == ENTRY) || accept)) ||
                   (AUTO_COMMIT && accept && (cnt_app == MAX_CNT));

  // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= EMPTY;
      acc           <= '0;
      cnt           <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else if (bus.clear) begin
      state         <= EMPTY;
      acc           <= '0;
      cnt           <= '0;
      value_valid_q <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      case (state)
        EMPTY, ENTRY: begin
          if (illegal) begin
            state   <= ERROR;
            error_q <= 1'b1;
          end else if (commit) begin
            acc <= acc_app;
            cnt <= cnt_app;
            if (acc_app <= MAX_ACC) begin
              value_q       <= acc_app[7:0];
              value_valid_q <= 1'b1;
              state         <= RESULT;
            end else begin
              error_q <= 1'b1;
              state   <= ERROR;
            end
          end else if (accept) begin
            acc   <= acc_app;
            cnt   <= cnt_app;
            state <= ENTRY;
          end
        end
        RESULT: begin
          if (bus.value_ready) begin
            value_valid_q <= 1'b0;
            acc           <= '0;
            cnt           <= '0;
            state         <= EMPTY;
          end
        end
        ERROR: begin
          state <= ERROR;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign bus.digit_ready = digit_ready;
  assign bus.digit_count = cnt;
  assign bus.value       = value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_decimal_entry_encoder.sv
// Directed, table-driven bench for decimal_entry_encoder (MAX_VALUE=150, MAX_DIGITS=3).
module tb_decimal_entry_encoder;

  logic clk;
  logic reset;

  decimal_entry_encoder_if bus ();

  decimal_entry_encoder #(.MAX_VALUE(150), .MAX_DIGITS(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;          // digits used, taken MSD first from the low n nibbles of dig
    logic [11:0] dig;
    logic        exp_valid;
    logic [7:0]  exp_value;
    logic        exp_error;
  } vec_t;

  vec_t vecs[10];
  int   n_checks;
  int   n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d);
    bus.digit_valid = 1'b1;
    bus.digit       = d;
    step();
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
  endtask

  task automatic pulse_enter();
    bus.enter = 1'b1;
    step();
    bus.enter = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic accept_result();
    bus.value_ready = 1'b1;
    step();
    bus.value_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.digit_valid = 1'b0;
    bus.digit       = 4'd0;
    bus.enter       = 1'b0;
    bus.clear       = 1'b0;
    bus.value_ready = 1'b0;

    vecs[0] = '{3, 12'h125, 1'b1, 8'd125, 1'b0};
    vecs[1] = '{3, 12'h151, 1'b0, 8'd0,   1'b1};
    vecs[2] = '{3, 12'h999, 1'b0, 8'd0,   1'b1};
    vecs[3] = '{3, 12'h150, 1'b1, 8'd150, 1'b0};
    vecs[4] = '{3, 12'h007, 1'b1, 8'd7,   1'b0};
    vecs[5] = '{1, 12'h000, 1'b1, 8'd0,   1'b0};
    vecs[6] = '{2, 12'h099, 1'b1, 8'd99,  1'b0};
    vecs[7] = '{3, 12'h255, 1'b0, 8'd0,   1'b1};
    vecs[8] = '{2, 12'h015, 1'b1, 8'd15,  1'b0};
    vecs[9] = '{3, 12'h149, 1'b1, 8'd149, 1'b0};

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    check("reset value",       32'(bus.value),       32'd0);
    check("reset value_valid", 32'(bus.value_valid), 32'd0);
    check("reset error",       32'(bus.error),       32'd0);
    check("reset digit_count", 32'(bus.digit_count), 32'd0);
    check("reset digit_ready", 32'(bus.digit_ready), 32'd1);

    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        send_digit(vecs[v].dig[(vecs[v].n - 1 - i) * 4 +: 4]);
        check($sformatf("v%0d digit_count after digit %0d", v, i), 32'(bus.digit_count), 32'(i + 1));
      end
      // With auto-commit a full entry has already committed; enter is then ignored.
      pulse_enter();
      check($sformatf("v%0d value_valid", v), 32'(bus.value_valid), 32'(vecs[v].exp_valid));
      check($sformatf("v%0d error", v),       32'(bus.error),       32'(vecs[v].exp_error));
      check($sformatf("v%0d digit_ready", v), 32'(bus.digit_ready), 32'd0);
      if (vecs[v].exp_valid) begin
        check($sformatf("v%0d value", v), 32'(bus.value), 32'(vecs[v].exp_value));
        accept_result();
        check($sformatf("v%0d valid after accept", v), 32'(bus.value_valid), 32'd0);
        check($sformatf("v%0d count after accept", v), 32'(bus.digit_count), 32'd0);
        check($sformatf("v%0d value retained", v),     32'(bus.value),       32'(vecs[v].exp_value));
      end else begin
        pulse_clear();
        check($sformatf("v%0d error after clear", v), 32'(bus.error),       32'd0);
        check($sformatf("v%0d ready after clear", v), 32'(bus.digit_ready), 32'd1);
        check($sformatf("v%0d count after clear", v), 32'(bus.digit_count), 32'd0);
      end
    end

    // Result held while value_ready stays low.
    send_digit(4'd1);
    send_digit(4'd5);
    send_digit(4'd0);
`ifndef DECIMAL_ENTRY_AUTO_COMMIT_EN
    check("hold pre-enter valid", 32'(bus.value_valid), 32'd0);
    pulse_enter();
`endif
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold value c%0d", c), 32'(bus.value),       32'd150);
      check($sformatf("hold valid c%0d", c), 32'(bus.value_valid), 32'd1);
      check($sformatf("hold ready c%0d", c), 32'(bus.digit_ready), 32'd0);
      step();
    end
    accept_result();
    check("hold released", 32'(bus.value_valid), 32'd0);

    // Illegal digit code in EMPTY; further digits ignored while in ERROR.
    send_digit(4'hA);
    check("illegal error", 32'(bus.error),       32'd1);
    check("illegal count", 32'(bus.digit_count), 32'd0);
    send_digit(4'd3);
    check("error ignores digit", 32'(bus.digit_count), 32'd0);
    check("error is sticky",     32'(bus.error),       32'd1);
    pulse_clear();
    check("illegal cleared", 32'(bus.error), 32'd0);

    // Fourth digit is not accepted.
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd3);
    send_digit(4'd4);
    check("4th digit count", 32'(bus.digit_count), 32'd3);
    check("4th digit error", 32'(bus.error),       32'd0);
    check("4th digit ready", 32'(bus.digit_ready), 32'd0);
    pulse_enter();
    check("4th digit value", 32'(bus.value),       32'd123);
    check("4th digit valid", 32'(bus.value_valid), 32'd1);
    accept_result();

    // Digit and enter in the same cycle from EMPTY.
    bus.enter = 1'b1;
    send_digit(4'd4);
    bus.enter = 1'b0;
    check("digit+enter valid", 32'(bus.value_valid), 32'd1);
    check("digit+enter value", 32'(bus.value),       32'd4);
    // clear discards an unaccepted result but keeps value.
    pulse_clear();
    check("clear in result valid", 32'(bus.value_valid), 32'd0);
    check("clear in result value", 32'(bus.value),       32'd4);

    // enter in EMPTY is ignored.
    pulse_enter();
    check("empty enter valid", 32'(bus.value_valid), 32'd0);
    check("empty enter ready", 32'(bus.digit_ready), 32'd1);

    // clear wins over a digit in ENTRY.
    send_digit(4'd1);
    bus.clear = 1'b1;
    send_digit(4'd2);
    bus.clear = 1'b0;
    check("clear+digit count", 32'(bus.digit_count), 32'd0);
    check("clear+digit ready", 32'(bus.digit_ready), 32'd1);
    pulse_enter();
    check("clear+digit no result", 32'(bus.value_valid), 32'd0);

`ifdef DECIMAL_ENTRY_AUTO_COMMIT_EN
    send_digit(4'd0);
    send_digit(4'd4);
    check("auto pre-commit valid", 32'(bus.value_valid), 32'd0);
    send_digit(4'd2);
    check("auto value", 32'(bus.value),       32'd42);
    check("auto valid", 32'(bus.value_valid), 32'd1);
    accept_result();
    send_digit(4'd2);
    send_digit(4'd0);
    send_digit(4'd0);
    check("auto over-range error", 32'(bus.error),       32'd1);
    check("auto over-range valid", 32'(bus.value_valid), 32'd0);
    pulse_clear();
`endif

    // reset mid-entry after a nonzero committed value.
    send_digit(4'd9);
    pulse_enter();
    accept_result();
    send_digit(4'd1);
    send_digit(4'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid reset value", 32'(bus.value),       32'd0);
    check("mid reset valid", 32'(bus.value_valid), 32'd0);
    check("mid reset error", 32'(bus.error),       32'd0);
    check("mid reset count", 32'(bus.digit_count), 32'd0);
    check("mid reset ready", 32'(bus.digit_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decimal_entry_encoder.md
Name: decimal_entry_encoder

Overview:
- Reverse direction of the counter-to-display path: takes decimal digits one at a time (most significant first) and encodes them into an 8-bit binary value limited to 0..MAX_VALUE (default 150).
- Sits between a keypad/digit source and any consumer of the 8-bit count, for example a counter preload.
- Valid/ready handshake on the digit input and on the result output.
- Out-of-range or illegal entries are flagged, never truncated.

Parameters:
- MAX_VALUE, 150: largest legal result; must be ≤ 255.
- MAX_DIGITS, 3: maximum digits per entry; must be ≤ 3.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- digit_valid  input  1  digit offered this cycle.
- digit  input  4  digit code; legal values 0..9.
- digit_ready  output  1  block can accept a digit.
- enter  input  1  single-cycle commit request.
- clear  input  1  abort current entry or error; return to EMPTY.
- value  output  8  committed binary result.
- value_valid  output  1  result available; held until accepted.
- value_ready  input  1  consumer accepts result.
- error  output  1  illegal digit or over-range commit; sticky until clear or reset.
- digit_count  output  2  digits accumulated so far (0..MAX_DIGITS).

Behaviour:
- Reset, synchronous, sampled on the rising clk edge:
  - State EMPTY; accumulator 0; digit_count 0.
  - value 0, value_valid 0, error 0.
  - digit_ready 1 in the first cycle after reset.
- States: EMPTY, ENTRY, RESULT, ERROR.
- digit_ready = 1 in EMPTY, and in ENTRY while digit_count < MAX_DIGITS; 0 otherwise. It is a registered/state function and never depends on digit_valid.
- Digit accept: digit_valid & digit_ready & digit ≤ 9.
  - Update: acc ← acc*10 + digit, digit_count + 1.
  - acc is 10 bits internally: 999 must not wrap; compare before narrowing.
  - EMPTY → ENTRY.
  - Leading zeros allowed: "0","0","7" gives 7.
- Illegal digit (digit_valid & digit_ready & digit > 9): → ERROR, error=1 the next cycle. The accumulator is not updated.
- digit_valid while digit_ready=0: ignored; no state change, no error.
- enter in ENTRY:
  - If acc ≤ MAX_VALUE: value ← acc[7:0], value_valid ← 1 the next cycle, → RESULT.
  - If acc > MAX_VALUE: → ERROR, value unchanged.
- enter in EMPTY: ignored (no result for an empty entry).
- enter in RESULT or ERROR: ignored.
- digit accept and enter in the same cycle: the digit is appended first; the commit uses the updated accumulator. Result or error appears the next cycle.
- RESULT:
  - value and value_valid are stable until value_ready=1.
  - On value_valid & value_ready: value_valid ← 0, acc/digit_count ← 0, → EMPTY.
  - value keeps its last committed value after the handshake.
- ERROR: error=1, digit_ready=0; exits only on clear (→ EMPTY, error ← 0).
- clear has priority over all other inputs in every state:
  - Next cycle: EMPTY, acc 0, digit_count 0, value_valid 0, error 0.
  - value is retained.
  - clear during RESULT discards an unaccepted result.
- reset mid-entry or mid-result gives exactly the reset state above.
- Latency: digit to digit_count update 1 cycle; enter to value_valid or error 1 cycle.

Optional Feature:
- Macro: DECIMAL_ENTRY_AUTO_COMMIT_EN.
- Defined: accepting the MAX_DIGITS-th digit performs an implicit enter in the same cycle, with the same range check and 1-cycle latency. An explicit enter in that cycle is redundant; the outcome is the same.
- Undefined: only an explicit enter commits. At MAX_DIGITS, digit_ready=0 until enter or clear.

Decomposition:
- Shared package decimal_entry_pkg:
  - State enum typedef (EMPTY, ENTRY, RESULT, ERROR).
  - Constants DIGIT_MAX=4'd9, ACC_W=10, DEFAULT_MAX_VALUE=8'd150.
  - Function times_ten_plus(acc, digit) returning ACC_W bits, implemented as (acc<<3)+(acc<<1)+digit.
- No sub-module needed; single FSM plus datapath. The ×10 add is a package function, not an instance.

Test Plan:
- Digits 1,2,5 then enter, value_ready=1 → value=8'd125, value_valid high 1 cycle after enter; then EMPTY, digit_count=0.
- Digits 1,5,1 then enter → error=1, value_valid=0, digit_ready=0. Then clear → error=0, EMPTY. Also digits 9,9,9 + enter → error; checks 10-bit accumulator has no wrap.
- Digits 1,5,0, enter with value_ready=0 held 5 cycles → value=150 stable, value_valid=1, digit_ready=0. value_ready=1 → value_valid=0 next cycle.
- digit=4'hA offered in EMPTY → error=1 next cycle, digit_count=0. A 4th digit with macro undefined → ignored, digit_count stays 3.
- Digit 4 with enter in the same cycle → value=4. enter in EMPTY → no value_valid. clear together with a digit in ENTRY → EMPTY, digit dropped.
- Macro defined: digits 0,4,2 with no enter → value=42, value_valid 1 cycle after the third digit. Digits 2,0,0 → error. reset mid-entry → all outputs at reset values.
